dma_mem_slave: RTL

Parametrised bus memory slave serving the SD host DMA port: a single-port word array with configurable read/write latency, data and address width. Unlike the fixed 8-bit, 6-cycle server, it latches address and data at accept and remaps addresses through an optional wrap window (base/len), as a DMA ring buffer needs. It flags out-of-range and rejected accesses and keeps saturating access counters for the bench scoreboard. It sits between the SDIO DMA engine and the bench-side memory image.

---
 rtl/dma_mem_slave.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dma_mem_slave.sv
// Parametrised word-array bus slave for the SD host DMA port.
// Remaps addresses through an optional ring window and keeps saturating statistics.
module dma_mem_slave #(
  parameter int DW     = 8,
  parameter int AW     = 17,
  parameter int DEPTH  = 131072,
  parameter int RD_LAT = 6,
  parameter int WR_LAT = 6,
  parameter int CNT_W  = 16
) (
  input  logic             bus_clk,
  input  logic             rst,
  input  logic             bus_rd,
  input  logic             bus_wr,
  input  logic [AW-1:0]    bus_addr,
  input  logic [DW-1:0]    bus_wdata,
  input  logic             win_en,
  input  logic [AW-1:0]    win_base,
  input  logic [AW-1:0]    win_len,
  output logic             bus_ready,
  output logic             bus_rdata_ready,
  output logic [DW-1:0]    bus_rdata,
  output logic             bus_err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rej_cnt
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [7:0]    RD_LD   = 8'(RD_LAT - 1);
  localparam logic [7:0]    WR_LD   = 8'(WR_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_t;

  state_t          state, state_n;
  logic [7:0]      lat_cnt;
  logic [IW-1:0]   idx_q;
  logic            bad_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   mem [DEPTH];

  logic            acc_rd, acc_wr, rej, done;
  logic [AW-1:0]   off, eff;
  logic            addr_bad;

  // One subtraction of win_len folds a single lap of ring overrun; anything further is invalid.
  always_comb begin
    off      = bus_addr;
    eff      = bus_addr;
    addr_bad = 1'b0;
    if (bus_addr >= win_len) off = bus_addr - win_len;
    if (win_en) begin
      eff = win_base + off;
      if (win_len == '0 || off >= win_len) addr_bad = 1'b1;
    end
    if ({1'b0, eff} >= DEPTH_L) addr_bad = 1'b1;
  end

  always_comb begin
    state_n = state;
    acc_rd  = 1'b0;
    acc_wr  = 1'b0;
    rej     = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus_rd && bus_wr) rej = 1'b1;
        else if (bus_rd) begin
          acc_rd  = 1'b1;
          state_n = RD_BUSY;
        end else if (bus_wr) begin
          acc_wr  = 1'b1;
          state_n = WR_BUSY;
        end
      end
      RD_BUSY, WR_BUSY: begin
        rej = bus_rd | bus_wr;
        if (lat_cnt == '0) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus_ready = (state == IDLE);

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      lat_cnt         <= '0;
      idx_q           <= '0;
      bad_q           <= 1'b0;
      wdata_q         <= '0;
      bus_rdata       <= '0;
      bus_rdata_ready <= 1'b0;
      bus_err         <= 1'b0;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
      rej_cnt         <= '0;
    end else begin
      state           <= state_n;
      bus_rdata_ready <= 1'b0;
      bus_err         <= rej;
      if (acc_rd || acc_wr) begin
        lat_cnt <= acc_rd ? RD_LD : WR_LD;
        idx_q   <= eff[IW-1:0];
        bad_q   <= addr_bad;
        wdata_q <= bus_wdata;
      end else if (lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 8'd1;
      end
      if (done && state == RD_BUSY) begin
        bus_rdata_ready <= 1'b1;
        bus_rdata       <= bad_q ? '1 : mem[idx_q];
        if (bad_q) bus_err <= 1'b1;
      end
      if (done && state == WR_BUSY && bad_q) bus_err <= 1'b1;
      if (acc_rd && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
      if (acc_wr && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
      if (rej && rej_cnt != '1) rej_cnt <= rej_cnt + 1'b1;
    end
  end

  // Array is left unreset; a reset clears state so an in-flight write never reaches here.
  always_ff @(posedge bus_clk) begin
    if (done && state == WR_BUSY && !bad_q) mem[idx_q] <= wdata_q;
  end

endmodule
